// File: rtl/div_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// div_unit
//
// Iterative restoring divider for the RV32M DIV / DIVU / REM / REMU group.
// It sits beside the sequential multiplier in the ALU mul/div path and shares
// its start/done handshake with the execute stage. One quotient bit is
// produced per clock, so every operation takes the same number of cycles,
// including divide-by-zero and signed overflow.
//
// Ports
//   clk     in   1   rising-edge clock
//   reset   in   1   asynchronous, active-low reset
//   start   in   1   request; only looked at while idle
//   op      in   2   00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   rs1     in   W   dividend, captured with start
//   rs2     in   W   divisor, captured with start
//   busy    out  1   high whenever an operation is in flight
//   done    out  1   one-cycle pulse, result valid
//   result  out  W   quotient or remainder, held until the next result
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int W  = 32,
    parameter int CW = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] rs1,
    input  logic [W-1:0] rs2,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [W-1:0]  MIN_NEG   = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] CNT_START = CW'(W - 1);

    state_t        r_state;
    state_t        w_next_state;

    logic [1:0]    r_op;       // latched operation code
    logic          r_sa;       // dividend was negative (signed ops only)
    logic          r_sb;       // divisor was negative (signed ops only)
    logic          r_dz;       // divide by zero
    logic          r_ovf;      // signed overflow: MIN_NEG / -1
    logic [W-1:0]  r_dvd;      // dividend magnitude, shifts into quotient
    logic [W-1:0]  r_dvs;      // divisor magnitude
    logic [W-1:0]  r_rem;      // partial remainder, always < divisor
    logic [CW-1:0] r_cnt;      // iterations still to run after this one
    logic [W-1:0]  r_result;
    logic          r_done;

    // ------------------------------------------------------------------------
    // Operand capture
    // ------------------------------------------------------------------------
    logic          w_signed_op;
    logic          w_rs1_neg;
    logic          w_rs2_neg;
    logic [W-1:0]  w_rs1_mag;
    logic [W-1:0]  w_rs2_mag;
    logic          w_dz;
    logic          w_ovf;
    logic          w_accept;

    assign w_signed_op = ~op[0];
    assign w_rs1_neg   = w_signed_op & rs1[W-1];
    assign w_rs2_neg   = w_signed_op & rs2[W-1];
    // MIN_NEG negates to itself, which is still the correct unsigned magnitude.
    assign w_rs1_mag   = w_rs1_neg ? (~rs1 + 1'b1) : rs1;
    assign w_rs2_mag   = w_rs2_neg ? (~rs2 + 1'b1) : rs2;
    assign w_dz        = (rs2 == '0);
    assign w_ovf       = w_signed_op & (rs1 == MIN_NEG) & (rs2 == '1);
    assign w_accept    = (r_state == S_IDLE) & start;

    // ------------------------------------------------------------------------
    // One restoring step
    // ------------------------------------------------------------------------
    // The trial value needs W+1 bits: the remainder is below a divisor that
    // may use all W bits, so shifting it left can carry out of bit W-1.
    logic [W:0]    w_trial;
    logic [W:0]    w_diff;
    logic          w_q_bit;
    logic [W-1:0]  w_rem_next;

    assign w_trial    = {r_rem, r_dvd[W-1]};
    assign w_diff     = w_trial - {1'b0, r_dvs};
    // No borrow out of the subtraction means trial >= divisor.
    assign w_q_bit    = ~w_diff[W];
    assign w_rem_next = w_q_bit ? w_diff[W-1:0] : w_trial[W-1:0];

    // ------------------------------------------------------------------------
    // Sign fix-up and special cases
    // ------------------------------------------------------------------------
    logic [W-1:0]  w_quot_signed;
    logic [W-1:0]  w_rem_signed;
    logic [W-1:0]  w_final;

    assign w_quot_signed = (r_sa ^ r_sb) ? (~r_dvd + 1'b1) : r_dvd;
    assign w_rem_signed  = r_sa ? (~r_rem + 1'b1) : r_rem;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch, so no path leaves it unassigned and no latch appears.
        w_final = r_op[1] ? w_rem_signed : w_quot_signed;
        if (r_dz) begin
            // With a zero divisor the loop leaves the whole dividend magnitude
            // in the remainder, so the signed remainder is already rs1.
            w_final = r_op[1] ? w_rem_signed : '1;
        end else if (r_ovf) begin
            w_final = r_op[1] ? '0 : MIN_NEG;
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_CALC;
            S_CALC:  if (r_cnt == '0) w_next_state = S_SIGN;
            S_SIGN:  w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the datapath is a handful of plain registers, not a memory
        // array, so all of it is cleared by reset and an abort leaves no
        // stale operand or result behind.
        if (!reset) begin
            r_op     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            // done is high exactly while the FSM sits in DONE.
            r_done <= (r_state == S_SIGN);

            if (w_accept) begin
                r_op  <= op;
                r_sa  <= w_rs1_neg;
                r_sb  <= w_rs2_neg;
                r_dz  <= w_dz;
                r_ovf <= w_ovf;
                r_dvd <= w_rs1_mag;
                r_dvs <= w_rs2_mag;
                r_rem <= '0;
                r_cnt <= CNT_START;
            end else if (r_state == S_CALC) begin
                r_rem <= w_rem_next;
                r_dvd <= {r_dvd[W-2:0], w_q_bit};
                // Hold at zero on the last step rather than wrapping.
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end else if (r_state == S_SIGN) begin
                r_result <= w_final;
            end
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign result = r_result;

endmodule
